// File: rtl/adder_lc_pkg.sv
// Shared types and constants for the adder launch/capture harness.
`default_nettype none

package adder_lc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LAUNCH  = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_FINISH  = 3'd4
   } state_t;

   localparam int          CNT_W   = 16;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hB400;

   function automatic logic [15:0] lfsr_taps(input int width);
      if (width == 16) begin
         return TAPS_16;
      end
      return {8'h00, TAPS_8};
   endfunction

endpackage

`default_nettype wire

// File: rtl/adder_launch_capture_lfsr.sv
// Galois right-shift LFSR with seed load, step enable and zero-seed guard.
`default_nettype none

module lc_lfsr
   import adder_lc_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] seed,
   input  logic         step,
   output logic [W-1:0] state
);

   localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= W'(1);
      end else if (load) begin
         // An all-zero state would never leave zero.
         state <= (seed == '0) ? W'(1) : seed;
      end else if (step) begin
         state <= {1'b0, state[W-1:1]} ^ (state[0] ? TAPS : '0);
      end
   end

endmodule

`default_nettype wire

// File: rtl/adder_launch_capture.sv
// Launch/capture harness: drives adder operands, waits SETTLE cycles, checks {C,S}.
`default_nettype none

module adder_launch_capture
   import adder_lc_pkg::*;
#(
   parameter int N      = 4,
   parameter int SETTLE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             lfsr_en,
   input  logic [2*N-1:0]   seed,
   input  logic [CNT_W-1:0] num_vectors,
   output logic [N-1:0]     A_drv,
   output logic [N-1:0]     B_drv,
   input  logic [N-1:0]     S_in,
   input  logic             C_in,
   output logic             busy,
   output logic             done,
   output logic             mismatch,
   output logic [CNT_W-1:0] err_count,
   output logic [N:0]       last_sum
);

   localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t             state, state_nxt;
   logic               lfsr_en_q;
   logic [2*N-1:0]     seed_q;
   logic [CNT_W-1:0]   vec_left;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [N:0]         exp_sum;
   logic [2*N-1:0]     lfsr_state;
   logic [2*N-1:0]     launch_vec;
   logic [N:0]         launch_sum;
   logic               lfsr_load;
   logic               lfsr_step;

   assign lfsr_load  = (state == ST_IDLE) && start;
   assign lfsr_step  = (state == ST_LAUNCH);
   assign launch_vec = lfsr_en_q ? lfsr_state : seed_q;
   assign launch_sum = {1'b0, launch_vec[N-1:0]} + {1'b0, launch_vec[2*N-1:N]};

   lc_lfsr #(
      .W (2*N)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lfsr_load),
      .seed  (seed),
      .step  (lfsr_step),
      .state (lfsr_state)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = (num_vectors != '0) ? ST_LAUNCH : ST_FINISH;
            end
         end
         ST_LAUNCH:  state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (wait_cnt == '0) begin
               state_nxt = ST_CAPTURE;
            end
         end
         ST_CAPTURE: state_nxt = (vec_left == CNT_W'(1)) ? ST_FINISH : ST_LAUNCH;
         ST_FINISH:  state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_FINISH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_en_q <= 1'b0;
         seed_q    <= '0;
         vec_left  <= '0;
         wait_cnt  <= '0;
         exp_sum   <= '0;
         A_drv     <= '0;
         B_drv     <= '0;
         mismatch  <= 1'b0;
         err_count <= '0;
         last_sum  <= '0;
      end else begin
         mismatch <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  lfsr_en_q <= lfsr_en;
                  seed_q    <= seed;
                  vec_left  <= num_vectors;
                  err_count <= '0;
               end
            end
            ST_LAUNCH: begin
               A_drv    <= launch_vec[N-1:0];
               B_drv    <= launch_vec[2*N-1:N];
               exp_sum  <= launch_sum;
               wait_cnt <= WAIT_W'(SETTLE - 1);
            end
            ST_WAIT: begin
               if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_CAPTURE: begin
               last_sum <= {C_in, S_in};
               vec_left <= vec_left - 1'b1;
               if ({C_in, S_in} != exp_sum) begin
                  mismatch <= 1'b1;
                  if (err_count != CNT_MAX) begin
                     err_count <= err_count + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_adder_launch_capture.sv
// Scoreboard bench for adder_launch_capture (N=4, SETTLE=3) with a behavioural adder.
`default_nettype none

module tb_adder_launch_capture;

   localparam int N      = 4;
   localparam int SETTLE = 3;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          lfsr_en;
   logic [7:0]    seed;
   logic [15:0]   num_vectors;
   logic [3:0]    A_drv, B_drv, S_in;
   logic          C_in;
   logic          busy, done, mismatch;
   logic [15:0]   err_count;
   logic [4:0]    last_sum;
   logic          corrupt;
   logic [4:0]    model_sum;

   adder_launch_capture #(.N(N), .SETTLE(SETTLE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .lfsr_en     (lfsr_en),
      .seed        (seed),
      .num_vectors (num_vectors),
      .A_drv       (A_drv),
      .B_drv       (B_drv),
      .S_in        (S_in),
      .C_in        (C_in),
      .busy        (busy),
      .done        (done),
      .mismatch    (mismatch),
      .err_count   (err_count),
      .last_sum    (last_sum)
   );

   // Behavioural adder; corrupt drops the carry-out.
   assign model_sum = {1'b0, A_drv} + {1'b0, B_drv};
   assign S_in      = model_sum[3:0];
   assign C_in      = corrupt ? 1'b0 : model_sum[4];

   typedef struct {
      int          done_cyc;
      logic [15:0] err;
      logic [4:0]  last;
      logic [7:0]  ops;
      int          mism;
   } exp_t;

   exp_t        sb_q[$];
   logic [7:0]  op_q[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: mismatch pulses are counted before a coincident done is scored.
   initial begin
      int         mism_cnt;
      logic [7:0] prev_ops;
      exp_t       e;
      mism_cnt = 0;
      prev_ops = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mism_cnt = 0;
         end else begin
            if (mismatch) mism_cnt++;
            if (busy && {B_drv, A_drv} != prev_ops && op_q.size() > 0) begin
               chk("launch_ops", {24'h0, B_drv, A_drv}, {24'h0, op_q.pop_front()});
            end
            if (done) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  chk("done_cycle", cyc, e.done_cyc);
                  chk("done_busy", {31'h0, busy}, 32'd1);
                  chk("err_count", {16'h0, err_count}, {16'h0, e.err});
                  chk("last_sum", {27'h0, last_sum}, {27'h0, e.last});
                  chk("operands", {24'h0, B_drv, A_drv}, {24'h0, e.ops});
                  chk("mismatch_pulses", mism_cnt, e.mism);
               end
               mism_cnt = 0;
            end
         end
         prev_ops = {B_drv, A_drv};
      end
   end

   task automatic launch_run(input logic le, input logic [7:0] sd, input logic [15:0] nv,
                             input logic [15:0] e_err, input logic [4:0] e_last,
                             input logic [7:0] e_ops, input int e_mism);
      exp_t e;
      @(negedge clk);
      lfsr_en     = le;
      seed        = sd;
      num_vectors = nv;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      e.done_cyc = cyc + int'(nv) * (SETTLE + 2);
      e.err      = e_err;
      e.last     = e_last;
      e.ops      = e_ops;
      e.mism     = e_mism;
      sb_q.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
      if (busy) chk({name, "_timeout"}, 32'd1, 32'd0);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] v;
      rst_n = 1'b0; start = 1'b0; lfsr_en = 1'b0; seed = 8'h00;
      num_vectors = 16'd0; corrupt = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);
      chk("rst_err", {16'h0, err_count}, 32'd0);
      chk("rst_ops", {24'h0, B_drv, A_drv}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Abort mid-WAIT: reset clears everything at once, no done follows.
      @(negedge clk);
      lfsr_en = 1'b0; seed = 8'hF9; num_vectors = 16'd1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midwait_busy", {31'h0, busy}, 32'd1);
      chk("midwait_ops", {24'h0, B_drv, A_drv}, 32'hF9);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'h0, busy}, 32'd0);
      chk("abort_done", {31'h0, done}, 32'd0);
      chk("abort_ops", {24'h0, B_drv, A_drv}, 32'd0);
      chk("abort_last", {27'h0, last_sum}, 32'd0);
      chk("abort_mismatch", {31'h0, mismatch}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort_idle", {31'h0, busy}, 32'd0);

      // Zero vectors: straight to FINISH, operands untouched.
      launch_run(1'b0, 8'hF9, 16'd0, 16'h0000, 5'h00, 8'h00, 0);
      wait_idle("zero");

      // Fixed pass, with start pulses during the run that must be ignored.
      op_q.push_back(8'hF9);
      launch_run(1'b0, 8'hF9, 16'd1, 16'h0000, 5'h18, 8'hF9, 0);
      @(negedge clk);
      seed = 8'h33; num_vectors = 16'd7; lfsr_en = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("fixed_pass");
      repeat (3) @(negedge clk);
      chk("busy_start_ignored", {31'h0, busy}, 32'd0);

      // Fixed fail: carry forced low.
      corrupt = 1'b1;
      launch_run(1'b0, 8'hF9, 16'd1, 16'h0001, 5'h08, 8'hF9, 1);
      wait_idle("fixed_fail");
      corrupt = 1'b0;

      // LFSR run from zero seed: 01, B8, 5C, 2E, ...
      op_q.push_back(8'h01);
      op_q.push_back(8'hB8);
      op_q.push_back(8'h5C);
      op_q.push_back(8'h2E);
      v = 8'h01;
      for (int i = 0; i < 299; i++) v = {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
      launch_run(1'b1, 8'h00, 16'd300, 16'h0000,
                 5'({1'b0, v[3:0]} + {1'b0, v[7:4]}), v, 0);
      wait_idle("lfsr");

      // Saturation: preload error count near the top, then three failing vectors.
      corrupt = 1'b1;
      launch_run(1'b0, 8'hF9, 16'd3, 16'hFFFF, 5'h08, 8'hF9, 3);
      force dut.err_count = 16'hFFFE;
      @(posedge clk);
      #1;
      release dut.err_count;
      chk("sat_preload", {16'h0, err_count}, 32'h0000FFFE);
      wait_idle("sat");
      corrupt = 1'b0;

      repeat (3) @(negedge clk);
      chk("sb_empty", sb_q.size(), 32'd0);
      chk("op_q_empty", op_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
